// File: rtl/vram_fill_pkg.sv
// Shared types and constants for the VRAM fill controller: FSM states,
// default MMIO addresses, fill length and CTRL register bit layout.
package vram_fill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2
  } fill_state_e;

  localparam logic [31:0] DEF_VRAM_BASE   = 32'hfbad_0000;
  localparam logic [31:0] DEF_COMMIT_ADDR = 32'hfbad_f000;
  localparam logic [31:0] DEF_CTRL_ADDR   = 32'hfbad_f004;
  localparam int unsigned DEF_VRAM_BYTES  = 32'd4800;

  localparam int unsigned CTRL_START_BIT = 32'd8;
  localparam int unsigned CTRL_AUTO_BIT  = 32'd9;
  localparam int unsigned CTRL_ABORT_BIT = 32'd10;

  localparam logic [2:0] ACC_SB = 3'b000;
  localparam logic [2:0] ACC_SW = 3'b010;

  function automatic logic [31:0] status_word(input logic auto_commit, input logic busy);
    return {30'b0, auto_commit, busy};
  endfunction

endpackage

// File: rtl/vram_fill_ctrl.sv
// MMIO port arbiter: passes CPU accesses through when idle and takes the port
// over to fill the back buffer with one colour, optionally committing the frame.
module vram_fill_ctrl
  import vram_fill_pkg::*;
#(
  parameter logic [31:0] VRAM_BASE   = DEF_VRAM_BASE,
  parameter int unsigned VRAM_BYTES  = DEF_VRAM_BYTES,
  parameter logic [31:0] COMMIT_ADDR = DEF_COMMIT_ADDR,
  parameter logic [31:0] CTRL_ADDR   = DEF_CTRL_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_load,
  input  logic        cpu_store,
  input  logic [2:0]  cpu_access,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_data_in,
  output logic [31:0] cpu_data_out,
  output logic        cpu_stall,
  output logic        m_load,
  output logic        m_store,
  output logic [2:0]  m_access,
  output logic [31:0] m_addr,
  output logic [31:0] m_data_in,
  input  logic [31:0] m_data_out,
  output logic        fill_done
);

  localparam logic [12:0] LAST_IDX = 13'(VRAM_BYTES - 32'd1);

  fill_state_e r_state;
  fill_state_e w_next_state;
  logic [12:0] r_idx;
  logic [7:0]  r_color;
  logic        r_auto_commit;
  logic        r_fill_done;

  logic        w_is_ctrl;
  logic        w_ctrl_wr;
  logic        w_start;
  logic        w_abort;
  logic        w_busy;
  logic        w_last;
  logic        w_ctrl_rd;
  logic [31:0] w_status;

  assign w_is_ctrl = (cpu_addr == CTRL_ADDR);
  assign w_ctrl_wr = cpu_store && (cpu_access == ACC_SW) && w_is_ctrl;
  assign w_ctrl_rd = cpu_load && w_is_ctrl;
  assign w_start   = w_ctrl_wr && cpu_data_in[CTRL_START_BIT];
  assign w_abort   = w_ctrl_wr && cpu_data_in[CTRL_ABORT_BIT];
  assign w_busy    = (r_state != ST_IDLE);
  assign w_last    = (r_idx == LAST_IDX);
  assign w_status  = status_word(r_auto_commit, w_busy);
  assign fill_done = r_fill_done;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; start beats abort in IDLE because abort is only checked while busy
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next_state = ST_FILL;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (w_abort) begin
          w_next_state = ST_IDLE;
        end else if (w_last) begin
          w_next_state = r_auto_commit ? ST_COMMIT : ST_IDLE;
        end else begin
          w_next_state = ST_FILL;
        end
      end
      ST_COMMIT: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Fill counter, latched command fields and completion pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx         <= 13'd0;
      r_color       <= 8'd0;
      r_auto_commit <= 1'b0;
      r_fill_done   <= 1'b0;
    end else begin
      r_fill_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_idx         <= 13'd0;
            r_color       <= cpu_data_in[7:0];
            r_auto_commit <= cpu_data_in[CTRL_AUTO_BIT];
          end
        end
        ST_FILL: begin
          r_idx       <= r_idx + 13'd1;
          r_fill_done <= w_last && !r_auto_commit && !w_abort;
        end
        ST_COMMIT: r_fill_done <= !w_abort;
        default:   r_fill_done <= 1'b0;
      endcase
    end
  end

  // Port mux: CPU passthrough in IDLE, engine requests while busy
  always_comb begin
    m_load       = 1'b0;
    m_store      = 1'b0;
    m_access     = cpu_access;
    m_addr       = cpu_addr;
    m_data_in    = cpu_data_in;
    cpu_stall    = 1'b0;
    cpu_data_out = 32'd0;
    case (r_state)
      ST_IDLE: begin
        m_load    = cpu_load && !w_is_ctrl;
        m_store   = cpu_store && !w_is_ctrl;
        cpu_stall = 1'b0;
      end
      ST_FILL: begin
        m_store   = 1'b1;
        m_access  = ACC_SB;
        m_addr    = VRAM_BASE + {19'd0, r_idx};
        m_data_in = {24'd0, r_color};
        cpu_stall = (cpu_load || cpu_store) && !w_is_ctrl;
      end
      ST_COMMIT: begin
        m_store   = 1'b1;
        m_access  = ACC_SB;
        m_addr    = COMMIT_ADDR;
        m_data_in = 32'd0;
        cpu_stall = (cpu_load || cpu_store) && !w_is_ctrl;
      end
      default: begin
        m_load    = 1'b0;
        m_store   = 1'b0;
        cpu_stall = 1'b0;
      end
    endcase
    if (w_ctrl_rd) begin
      cpu_data_out = w_status;
    end else if (!w_busy) begin
      cpu_data_out = m_data_out;
    end else begin
      cpu_data_out = 32'd0;
    end
  end

endmodule

// File: tb/tb_vram_fill_ctrl.sv
// Scoreboard bench for vram_fill_ctrl: expected MMIO requests are queued by the
// stimulus and popped by a monitor whenever the DUT strobes m_load/m_store.
module tb_vram_fill_ctrl;

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [2:0]  acc;
    logic [31:0] addr;
    logic [31:0] data;
  } mreq_t;

  localparam logic [31:0] BASE   = 32'hfbad_0000;
  localparam logic [31:0] COMMIT = 32'hfbad_f000;
  localparam logic [31:0] CTRL   = 32'hfbad_f004;
  localparam int          NBYTES = 4800;

  logic        clk;
  logic        rst;
  logic        cpu_load;
  logic        cpu_store;
  logic [2:0]  cpu_access;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_data_in;
  logic [31:0] cpu_data_out;
  logic        cpu_stall;
  logic        m_load;
  logic        m_store;
  logic [2:0]  m_access;
  logic [31:0] m_addr;
  logic [31:0] m_data_in;
  logic [31:0] m_data_out;
  logic        fill_done;

  int    n_tests;
  int    n_fail;
  mreq_t exp_q[$];

  vram_fill_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_load(cpu_load), .cpu_store(cpu_store), .cpu_access(cpu_access),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_data_out(cpu_data_out), .cpu_stall(cpu_stall),
    .m_load(m_load), .m_store(m_store), .m_access(m_access),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_data_out(m_data_out),
    .fill_done(fill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic ld, input logic st, input logic [2:0] acc,
                      input logic [31:0] addr, input logic [31:0] data);
    mreq_t r;
    r.ld = ld; r.st = st; r.acc = acc; r.addr = addr; r.data = data;
    exp_q.push_back(r);
  endtask

  task automatic push_fill(input logic [7:0] color, input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b1, 3'b000, BASE + 32'(i), {24'd0, color});
  endtask

  task automatic cpu_idle();
    cpu_load = 1'b0; cpu_store = 1'b0; cpu_access = 3'b000;
    cpu_addr = 32'd0; cpu_data_in = 32'd0;
  endtask

  task automatic cpu_req(input logic ld, input logic st, input logic [2:0] acc,
                         input logic [31:0] addr, input logic [31:0] data);
    cpu_load = ld; cpu_store = st; cpu_access = acc; cpu_addr = addr; cpu_data_in = data;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Start command sampled at edge 0; returns 1 ns into cycle 1.
  task automatic issue_start(input logic [31:0] word);
    cpu_req(1'b0, 1'b1, 3'b010, CTRL, word);
    @(negedge clk);
    chk("start_no_stall", {31'd0, cpu_stall}, 32'd0);
    next_cycle();
    cpu_idle();
  endtask

  task automatic read_status(output logic [31:0] val);
    cpu_req(1'b1, 1'b0, 3'b010, CTRL, 32'd0);
    @(negedge clk);
    val = cpu_data_out;
    chk("status_no_stall", {31'd0, cpu_stall}, 32'd0);
    next_cycle();
    cpu_idle();
  endtask

  // Monitor: every MMIO strobe must match the head of the expectation queue
  always @(negedge clk) begin
    if (m_load || m_store) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_req: got ld=%b st=%b addr=%h data=%h expected none at %0t",
                 m_load, m_store, m_addr, m_data_in, $time);
      end else begin
        mreq_t e;
        mreq_t a;
        e = exp_q.pop_front();
        a.ld = m_load; a.st = m_store; a.acc = m_access; a.addr = m_addr; a.data = m_data_in;
        if (a !== e) begin
          n_fail++;
          $display("FAIL mmio_req: got ld=%b st=%b acc=%b addr=%h data=%h expected ld=%b st=%b acc=%b addr=%h data=%h at %0t",
                   a.ld, a.st, a.acc, a.addr, a.data, e.ld, e.st, e.acc, e.addr, e.data, $time);
        end
      end
    end
  end

  initial begin
    logic [31:0] st;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    m_data_out = 32'h1234_5678;
    cpu_idle();

    // Reset state: status reads 0, outputs follow the IDLE passthrough rules
    next_cycle();
    cpu_req(1'b1, 1'b0, 3'b010, CTRL, 32'd0);
    @(negedge clk);
    chk("rst_status", cpu_data_out, 32'd0);
    chk("rst_fill_done", {31'd0, fill_done}, 32'd0);
    next_cycle();
    push(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0);
    cpu_req(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0);
    @(negedge clk);
    chk("rst_pass_data", cpu_data_out, 32'h1234_5678);
    next_cycle();
    rst = 1'b1;
    cpu_idle();
    next_cycle();

    // Passthrough load and store in IDLE
    push(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0);
    cpu_req(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0);
    @(negedge clk);
    chk("pass_ld_data", cpu_data_out, 32'h1234_5678);
    chk("pass_ld_stall", {31'd0, cpu_stall}, 32'd0);
    next_cycle();
    push(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'hcafe_f00d);
    cpu_req(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'hcafe_f00d);
    @(negedge clk);
    chk("pass_st_stall", {31'd0, cpu_stall}, 32'd0);
    next_cycle();

    // sh to CTRL with start set is ignored and not forwarded
    cpu_req(1'b0, 1'b1, 3'b001, CTRL, 32'h0000_0155);
    next_cycle();
    cpu_idle();
    next_cycle();
    read_status(st);
    chk("sh_ctrl_ignored", st, 32'd0);

    // Fill with commit, CTRL read, ignored restart and a stalled RAM load
    m_data_out = 32'hdead_beef;
    push_fill(8'h55, NBYTES);
    push(1'b0, 1'b1, 3'b000, COMMIT, 32'd0);
    push(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'd0);
    issue_start(32'h0000_0355);
    for (int c = 1; c <= NBYTES + 4; c++) begin
      if (c == 5) cpu_req(1'b1, 1'b0, 3'b000, CTRL, 32'd0);
      else if (c == 7) cpu_req(1'b0, 1'b1, 3'b010, CTRL, 32'h0000_0177);
      else if (c >= 10 && c <= NBYTES + 2) cpu_req(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'd0);
      else cpu_idle();
      @(negedge clk);
      chk("fc_fill_done", {31'd0, fill_done}, {31'd0, c == NBYTES + 2});
      if (c == 5) begin
        chk("fc_ctrl_lb", cpu_data_out, 32'h0000_0003);
        chk("fc_ctrl_lb_stall", {31'd0, cpu_stall}, 32'd0);
      end
      if (c == 7) chk("fc_restart_stall", {31'd0, cpu_stall}, 32'd0);
      if (c >= 10 && c <= NBYTES + 1) begin
        chk("fc_stall", {31'd0, cpu_stall}, 32'd1);
        chk("fc_stall_data", cpu_data_out, 32'd0);
      end
      if (c == NBYTES + 2) begin
        chk("fc_release_stall", {31'd0, cpu_stall}, 32'd0);
        chk("fc_release_data", cpu_data_out, 32'hdead_beef);
      end
      next_cycle();
    end
    read_status(st);
    chk("fc_status_busy", {31'd0, st[0]}, 32'd0);
    chk("fc_queue_empty", 32'(exp_q.size()), 32'd0);

    // Fill without commit; start and abort together in IDLE still start
    push_fill(8'haa, NBYTES);
    issue_start(32'h0000_05aa);
    for (int c = 1; c <= NBYTES + 3; c++) begin
      @(negedge clk);
      chk("nc_fill_done", {31'd0, fill_done}, {31'd0, c == NBYTES + 1});
      next_cycle();
    end
    read_status(st);
    chk("nc_status", st, 32'd0);
    chk("nc_queue_empty", 32'(exp_q.size()), 32'd0);

    // Abort presented while byte 98 is being written
    push_fill(8'h11, 99);
    issue_start(32'h0000_0311);
    for (int c = 1; c <= 120; c++) begin
      if (c == 99) cpu_req(1'b0, 1'b1, 3'b010, CTRL, 32'h0000_0400);
      else cpu_idle();
      @(negedge clk);
      chk("ab_fill_done", {31'd0, fill_done}, 32'd0);
      if (c == 99) chk("ab_stall", {31'd0, cpu_stall}, 32'd0);
      next_cycle();
    end
    read_status(st);
    chk("ab_status_busy", {31'd0, st[0]}, 32'd0);
    chk("ab_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset asserted at the start of cycle 50 stops the engine at once
    push_fill(8'hcc, 49);
    issue_start(32'h0000_03cc);
    for (int c = 1; c <= 60; c++) begin
      if (c == 50) rst = 1'b0;
      if (c == 53) rst = 1'b1;
      if (c == 51) cpu_req(1'b1, 1'b0, 3'b000, CTRL, 32'd0);
      else cpu_idle();
      @(negedge clk);
      chk("rs_fill_done", {31'd0, fill_done}, 32'd0);
      if (c == 51) chk("rs_status_in_reset", cpu_data_out, 32'd0);
      next_cycle();
    end
    read_status(st);
    chk("rs_status", st, 32'd0);
    chk("rs_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
